// File: rtl/pipe_stage_elastic.sv
// Two-entry elastic pipeline stage: a skid buffer that breaks the ready path while
// sustaining one word per cycle, with flush, global enable and a backpressure counter.
module pipe_stage_elastic #(
    parameter int DATA_W    = 64,
    parameter int CNT_W     = 16,
    parameter int FLUSH_CLR = 0
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;
    logic              pop;

    assign in_ready  = en && (state_q != FULL);
    assign out_valid = en && (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = main_q;
    assign stall_cnt = cnt_q;
    assign occupancy = state_q;

    // Flush wins over every transition and works even while the stage is disabled.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            if (FLUSH_CLR != 0) begin
                main_d = '0;
                skid_d = '0;
            end
        end else if (en) begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // out_valid already carries en, so a disabled stage never counts stalls.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_pipe_stage_elastic;

    logic        clk = 1'b0;
    logic        arst;
    logic        en, flush, in_valid, out_ready, cnt_clr;
    logic [31:0] in_data;

    logic        in_ready1, out_valid1, in_ready2, out_valid2;
    logic [31:0] out_data1, out_data2;
    logic [15:0] stall1;
    logic [3:0]  stall2;
    logic [1:0]  occ1, occ2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(32), .CNT_W(16), .FLUSH_CLR(1)) dut1 (
        .clk(clk), .arst(arst), .en(en), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready1), .out_valid(out_valid1),
        .out_data(out_data1), .out_ready(out_ready), .cnt_clr(cnt_clr),
        .stall_cnt(stall1), .occupancy(occ1));

    pipe_stage_elastic #(.DATA_W(32), .CNT_W(4), .FLUSH_CLR(0)) dut2 (
        .clk(clk), .arst(arst), .en(en), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready2), .out_valid(out_valid2),
        .out_data(out_data2), .out_ready(out_ready), .cnt_clr(cnt_clr),
        .stall_cnt(stall2), .occupancy(occ2));

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic [1:0]  eocc;
        logic        eov;
        logic [31:0] edata;
        logic [15:0] estall;
        logic        eir;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iv, logic [31:0] d, logic ordy, logic [1:0] eocc,
                                logic eov, logic [31:0] edata, logic [15:0] estall, logic eir);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.eocc = eocc;
        v.eov = eov; v.edata = edata; v.estall = estall; v.eir = eir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic iv, input logic [31:0] d,
                         input logic ordy, input logic fl, input logic clr);
        en = e; in_valid = iv; in_data = d; out_ready = ordy; flush = fl; cnt_clr = clr;
    endtask

    logic [31:0] q[$];
    int          m1, m2, s_hold;
    logic        eir, eov, acc, pp;

    initial begin
        arst = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        #1;
        chk("rst_occ", 64'(occ1), 64'd0);
        chk("rst_ov", 64'(out_valid1), 64'd0);
        chk("rst_data", 64'(out_data1), 64'd0);
        chk("rst_stall", 64'(stall1), 64'd0);
        chk("rst_in_ready", 64'(in_ready1), 64'd1);
        @(negedge clk);
        arst = 1'b0;

        // Streaming, then backpressure with ordered drain
        for (int i = 1; i <= 10; i++)
            tbl.push_back(mk(1, 32'(i), 1, 2'd1, 1, 32'(i), 16'd0, 1));
        tbl.push_back(mk(0, 0, 1, 2'd0, 0, 32'd10, 16'd0, 1));
        tbl.push_back(mk(1, 32'hA, 0, 2'd1, 1, 32'hA, 16'd0, 1));
        tbl.push_back(mk(1, 32'hB, 0, 2'd2, 1, 32'hA, 16'd1, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 0, 0, 2'd2, 1, 32'hA, 16'(2 + k), 0));
        tbl.push_back(mk(0, 0, 1, 2'd1, 1, 32'hB, 16'd6, 1));
        tbl.push_back(mk(0, 0, 1, 2'd0, 0, 32'hB, 16'd6, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(1, tbl[i].iv, tbl[i].d, tbl[i].ordy, 0, 0);
            tick();
            chk("tbl_occ", 64'(occ1), 64'(tbl[i].eocc));
            chk("tbl_ov", 64'(out_valid1), 64'(tbl[i].eov));
            chk("tbl_data", 64'(out_data1), 64'(tbl[i].edata));
            chk("tbl_stall", 64'(stall1), 64'(tbl[i].estall));
            chk("tbl_in_ready", 64'(in_ready1), 64'(tbl[i].eir));
            chk("tbl_occ2", 64'(occ2), 64'(tbl[i].eocc));
        end

        // Flush of a full stage with a simultaneous offer
        drive(1, 0, 0, 0, 0, 1); tick();
        drive(1, 1, 32'hA, 0, 0, 0); tick();
        drive(1, 1, 32'hB, 0, 0, 0); tick();
        chk("fl_full", 64'(occ1), 64'd2);
        drive(1, 1, 32'hC, 0, 1, 0); tick();
        chk("fl_occ", 64'(occ1), 64'd0);
        chk("fl_ov", 64'(out_valid1), 64'd0);
        chk("fl_data_clr", 64'(out_data1), 64'd0);
        chk("fl_occ2", 64'(occ2), 64'd0);
        chk("fl_data_keep", 64'(out_data2), 64'hA);
        drive(1, 0, 0, 1, 0, 0); tick();
        chk("fl_c_dropped", 64'(occ1), 64'd0);

        // Enable gating
        drive(1, 0, 0, 0, 0, 1); tick();
        drive(1, 1, 32'h5, 0, 0, 0); tick();
        s_hold = int'(stall1);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 32'h77, 0, 0, 0);
            #1;
            chk("en_in_ready", 64'(in_ready1), 64'd0);
            chk("en_ov", 64'(out_valid1), 64'd0);
            tick();
        end
        chk("en_stall", 64'(stall1), 64'(s_hold));
        chk("en_occ", 64'(occ1), 64'd1);
        drive(1, 0, 0, 0, 0, 0);
        #1;
        chk("en_ov_back", 64'(out_valid1), 64'd1);
        chk("en_data", 64'(out_data1), 64'h5);
        out_ready = 1'b1;
        tick();
        chk("en_drain", 64'(occ1), 64'd0);

        // Stall counter saturation and clear priority
        drive(1, 0, 0, 0, 0, 1); tick();
        drive(1, 1, 32'h7, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) tick();
        chk("sat_stall4", 64'(stall2), 64'd15);
        chk("sat_stall16", 64'(stall1), 64'd20);
        drive(1, 0, 0, 0, 0, 1); tick();
        chk("clr_stall4", 64'(stall2), 64'd0);
        chk("clr_stall16", 64'(stall1), 64'd0);
        drive(1, 0, 0, 1, 0, 0); tick();

        // Asynchronous reset between edges while full
        drive(1, 1, 32'hA, 0, 0, 0); tick();
        drive(1, 1, 32'hB, 0, 0, 0); tick();
        @(negedge clk);
        #2 arst = 1'b1;
        #1;
        chk("ar_occ", 64'(occ1), 64'd0);
        chk("ar_ov", 64'(out_valid1), 64'd0);
        chk("ar_data", 64'(out_data1), 64'd0);
        chk("ar_data2", 64'(out_data2), 64'd0);
        chk("ar_stall", 64'(stall1), 64'd0);
        chk("ar_in_ready", 64'(in_ready1), 64'd1);
        tick();
        chk("ar_hold_occ", 64'(occ1), 64'd0);
        @(negedge clk);
        arst = 1'b0;

        // Random traffic against a FIFO model
        q.delete();
        m1 = 0;
        m2 = 0;
        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 8) != 0, ($urandom % 4) != 0, $urandom,
                  ($urandom % 3) != 0, ($urandom % 32) == 0, ($urandom % 40) == 0);
            #1;
            eir = en && (q.size() < 2);
            eov = en && (q.size() > 0);
            chk("rnd_in_ready", 64'(in_ready1), 64'(eir));
            chk("rnd_ov", 64'(out_valid1), 64'(eov));
            chk("rnd_occ", 64'(occ1), 64'(q.size()));
            chk("rnd_occ2", 64'(occ2), 64'(q.size()));
            chk("rnd_stall", 64'(stall1), 64'(m1));
            chk("rnd_stall4", 64'(stall2), 64'(m2));
            if (eov) begin
                chk("rnd_data", 64'(out_data1), 64'(q[0]));
                chk("rnd_data2", 64'(out_data2), 64'(q[0]));
            end
            acc = in_valid && eir;
            pp  = eov && out_ready;
            if (cnt_clr) begin
                m1 = 0;
                m2 = 0;
            end else if (eov && !out_ready) begin
                if (m1 < 65535) m1++;
                if (m2 < 15) m2++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (pp) void'(q.pop_front());
                if (acc) q.push_back(in_data);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
REQ-001 Parameter DATA_W, default 64, width of the payload carried through the stage.
REQ-002 Parameter CNT_W, default 16, width of the backpressure stall counter.
REQ-003 Parameter FLUSH_CLR, default 0: 1 = flush zeroes stored payload; 0 = flush invalidates only.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 arst  input  1  reset; asynchronous and active-high.
REQ-006 en  input  1  global stage enable, same meaning as the CPU enable.
REQ-007 flush  input  1  synchronous discard of all stored entries.
REQ-008 in_valid  input  1  upstream offers in_data.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 in_ready  output  1  stage can accept a word this cycle.
REQ-011 out_valid  output  1  out_data holds a valid word.
REQ-012 out_data  output  DATA_W  oldest stored payload.
REQ-013 out_ready  input  1  downstream accepts out_data this cycle.
REQ-014 cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-015 stall_cnt  output  CNT_W  count of backpressured cycles.
REQ-016 occupancy  output  2  number of stored entries, 0..2.

Function
REQ-017 Storage SHALL be a 2-entry skid buffer: main register (drives out_data) and skid register; state EMPTY(0), ONE(1), FULL(2) equals occupancy.
REQ-018 in_ready SHALL equal en AND (state != FULL); out_valid SHALL equal en AND (state != EMPTY).
REQ-019 accept = in_valid AND in_ready; pop = out_valid AND out_ready; no transfer of either kind when en=0.
REQ-020 EMPTY: accept -> ONE, main <= in_data.
REQ-021 ONE: accept AND pop -> ONE, main <= in_data; accept only -> FULL, skid <= in_data; pop only -> EMPTY.
REQ-022 FULL: pop -> ONE, main <= skid; no pop -> hold (accept impossible).
REQ-023 Latency SHALL be 1 cycle: word accepted in cycle N visible on out_data with out_valid in cycle N+1 when stage was EMPTY.
REQ-024 Throughput SHALL be one word per cycle while out_ready stays 1; no bubble inserted by the stage.
REQ-025 Order SHALL be strictly FIFO; no word duplicated or dropped except by flush.
REQ-026 flush SHALL have priority over all transitions: next state EMPTY, accept in same cycle ignored (word lost upstream by design), pop in same cycle still counts as delivered.
REQ-027 With FLUSH_CLR=1, flush SHALL zero main and skid; with FLUSH_CLR=0 their contents are unchanged but invalid.
REQ-028 en=0 SHALL freeze state, payload registers and stall_cnt; flush and cnt_clr still take effect when en=0.
REQ-029 stall_cnt SHALL increment by 1 each cycle with out_valid=1 AND out_ready=0, saturating at 2^CNT_W-1 (no wrap).
REQ-030 cnt_clr SHALL set stall_cnt to 0 and has priority over increment in the same cycle.
REQ-031 Payload registers SHALL load only on the transitions above; no other register writes.

Reset
REQ-032 arst=1 SHALL immediately force state EMPTY, main=0, skid=0, stall_cnt=0, independent of clk.
REQ-033 Outputs during and after reset: out_valid=0, occupancy=0, out_data=0, stall_cnt=0, in_ready=en.
REQ-034 Reset asserted mid-transfer SHALL discard all stored words; first cycle after release behaves as EMPTY.

Verification
REQ-035 Streaming: en=1, out_ready=1, in_valid=1 with data 1,2,3,... for 10 cycles -> out_data 1..10 on consecutive cycles one cycle later, occupancy stays 1, stall_cnt=0.
REQ-036 Backpressure: load 0xA then 0xB with out_ready=0 -> occupancy 2, in_ready=0; hold 5 cycles -> stall_cnt=6; raise out_ready -> 0xA then 0xB delivered in order, occupancy 0.
REQ-037 Flush: FULL with 0xA,0xB, FLUSH_CLR=1, flush=1 with in_valid=1 data 0xC -> next cycle occupancy 0, out_valid=0, out_data=0, 0xC not stored.
REQ-038 Enable gating: occupancy 1 holding 0x5, en=0 for 4 cycles with out_ready=0 and in_valid=1 -> in_ready=0, out_valid=0, stall_cnt unchanged; en=1 -> 0x5 presented.
REQ-039 Saturation: CNT_W=4, 20 stalled cycles -> stall_cnt=15; cnt_clr in stalled cycle -> stall_cnt=0.
REQ-040 Async reset: assert arst between clock edges while FULL -> outputs reach reset values before next clk edge; random traffic after release matches a reference FIFO model.
